// File: rtl/maxpool_relu2_pkg.sv
// Shared CNN definitions: conv2 output geometry, pooling factor, pixel format
// and the per-beat phase enables the pooling top hands to each channel slice.
package maxpool_relu2_pkg;

    localparam int CONV2_OUT_W = 8;
    localparam int CONV2_OUT_H = 8;
    localparam int POOL        = 2;
    localparam int DATA_BITS   = 12;

    // Signed pixel as produced by conv2 and consumed by the FC input
    typedef logic signed [DATA_BITS-1:0] pixel_t;

    // What a valid beat means for a channel slice, decoded once in the top
    typedef struct packed {
        logic pairLoad;
        logic bufWrite;
        logic outFire;
    } phase_t;

    // Index width that stays legal even for a single-entry range
    function automatic int idxBits(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/maxpool_relu2_ch.sv
// One channel of the 2x2 max-pool + ReLU: horizontal pair register,
// half-row buffer of horizontal maxima, final compare, ReLU and output register.
module maxpool_relu2_ch
    import maxpool_relu2_pkg::*;
#(
    parameter int WIDTH     = maxpool_relu2_pkg::CONV2_OUT_W,
    parameter int DATA_BITS = maxpool_relu2_pkg::DATA_BITS,
    parameter int IDX_W     = idxBits(WIDTH / POOL)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  phase_t                      phase_i,
    input  logic [IDX_W-1:0]            bufIdx_i,
    input  logic signed [DATA_BITS-1:0] pix_i,
    output logic signed [DATA_BITS-1:0] maxValue_o
);

    localparam int HALF_W = WIDTH / POOL;

    logic signed [DATA_BITS-1:0] pair_q;
    logic signed [DATA_BITS-1:0] halfRow_q [HALF_W];
    logic signed [DATA_BITS-1:0] maxValue_q;

    logic signed [DATA_BITS-1:0] horizMax;
    logic signed [DATA_BITS-1:0] bufEntry;
    logic signed [DATA_BITS-1:0] windowMax;
    logic signed [DATA_BITS-1:0] reluVal;

    // Horizontal max of the current pair, vertical max against the upper row, then clamp negatives
    always_comb begin
        bufEntry  = halfRow_q[bufIdx_i];
        horizMax  = (pair_q > pix_i) ? pair_q : pix_i;
        windowMax = (horizMax > bufEntry) ? horizMax : bufEntry;
        reluVal   = windowMax[DATA_BITS-1] ? '0 : windowMax;
    end

    // Left pixel of each horizontal pair waits here for its right neighbour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q <= '0;
        end else if (phase_i.pairLoad) begin
            pair_q <= pix_i;
        end
    end

    // Even rows park their horizontal maxima until the odd row below arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HALF_W; i++) begin
                halfRow_q[i] <= '0;
            end
        end else if (phase_i.bufWrite) begin
            halfRow_q[bufIdx_i] <= horizMax;
        end
    end

    // Result register updates only when a window closes and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxValue_q <= '0;
        end else if (phase_i.outFire) begin
            maxValue_q <= reluVal;
        end
    end

    assign maxValue_o = maxValue_q;

endmodule

// File: rtl/maxpool_relu2.sv
// 2x2 stride-2 max-pool followed by ReLU over three conv2 channels that share
// one valid. Raster counters and the output strobe live here; each channel's
// datapath lives in its own slice.
module maxpool_relu2
    import maxpool_relu2_pkg::*;
#(
    parameter int WIDTH     = maxpool_relu2_pkg::CONV2_OUT_W,
    parameter int HEIGHT    = maxpool_relu2_pkg::CONV2_OUT_H,
    parameter int DATA_BITS = maxpool_relu2_pkg::DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] conv_out_1,
    input  logic signed [DATA_BITS-1:0] conv_out_2,
    input  logic signed [DATA_BITS-1:0] conv_out_3,
    output logic signed [DATA_BITS-1:0] max_value_1,
    output logic signed [DATA_BITS-1:0] max_value_2,
    output logic signed [DATA_BITS-1:0] max_value_3,
    output logic                        valid_out_relu
);

    localparam int HALF_W = WIDTH / POOL;
    localparam int IDX_W  = idxBits(HALF_W);
    localparam int COL_W  = idxBits(WIDTH);
    localparam int ROW_W  = idxBits(HEIGHT);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic             strobe_q;
    phase_t           phase;
    logic [IDX_W-1:0] bufIdx;

    // Raster position advances per valid beat, wrapping into the next frame without a gap
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_q == COL_W'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Decode what this beat does inside its 2x2 window, shared by all channels
    always_comb begin
        phase.pairLoad = valid_in & ~col_q[0];
        phase.bufWrite = valid_in &  col_q[0] & ~row_q[0];
        phase.outFire  = valid_in &  col_q[0] &  row_q[0];
        bufIdx         = IDX_W'(col_q >> 1);
    end

    // Counter state plus a one-cycle strobe aligned with the channel result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            strobe_q <= phase.outFire;
        end
    end

    assign valid_out_relu = strobe_q;

    maxpool_relu2_ch #(
        .WIDTH     (WIDTH),
        .DATA_BITS (DATA_BITS),
        .IDX_W     (IDX_W)
    ) u_ch1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_i    (phase),
        .bufIdx_i   (bufIdx),
        .pix_i      (conv_out_1),
        .maxValue_o (max_value_1)
    );

    maxpool_relu2_ch #(
        .WIDTH     (WIDTH),
        .DATA_BITS (DATA_BITS),
        .IDX_W     (IDX_W)
    ) u_ch2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_i    (phase),
        .bufIdx_i   (bufIdx),
        .pix_i      (conv_out_2),
        .maxValue_o (max_value_2)
    );

    maxpool_relu2_ch #(
        .WIDTH     (WIDTH),
        .DATA_BITS (DATA_BITS),
        .IDX_W     (IDX_W)
    ) u_ch3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_i    (phase),
        .bufIdx_i   (bufIdx),
        .pix_i      (conv_out_3),
        .maxValue_o (max_value_3)
    );

endmodule

// File: tb/tb_maxpool_relu2.sv
// Bench for maxpool_relu2: directed frames with randomized filler data, checked
// every cycle against a frame-buffer reference model of pool-then-ReLU.
module tb_maxpool_relu2;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DB = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 valid_in;
    logic signed [DB-1:0] conv_out_1;
    logic signed [DB-1:0] conv_out_2;
    logic signed [DB-1:0] conv_out_3;
    logic signed [DB-1:0] max_value_1;
    logic signed [DB-1:0] max_value_2;
    logic signed [DB-1:0] max_value_3;
    logic                 valid_out_relu;

    int checks = 0;
    int errors = 0;

    int          beatIdx;
    int          frameMem [3][H][W];
    logic [11:0] expOut [3];
    logic        expStrobe;
    int          strobeCount;
    int          cap1 [$];
    int          cap2 [$];
    int          cap3 [$];

    // Free-running clock
    always #5 clk = ~clk;

    maxpool_relu2 #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .DATA_BITS (DB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .conv_out_1     (conv_out_1),
        .conv_out_2     (conv_out_2),
        .conv_out_3     (conv_out_3),
        .max_value_1    (max_value_1),
        .max_value_2    (max_value_2),
        .max_value_3    (max_value_3),
        .valid_out_relu (valid_out_relu)
    );

    function automatic int toSigned(input logic [11:0] v);
        logic signed [11:0] s;
        s = v;
        return s;
    endfunction

    function automatic logic [11:0] poolRelu(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 0) ? 12'd0 : 12'(m);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearCapture();
        strobeCount = 0;
        cap1.delete();
        cap2.delete();
        cap3.delete();
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] a, input logic [11:0] b,
                                 input logic [11:0] c);
        int r;
        int cl;
        int wv [3];
        @(negedge clk);
        valid_in   = v;
        conv_out_1 = a;
        conv_out_2 = b;
        conv_out_3 = c;
        expStrobe  = 1'b0;
        if (!rst_n) begin
            beatIdx = 0;
            for (int k = 0; k < 3; k++) expOut[k] = 12'd0;
        end else if (v) begin
            r  = beatIdx / W;
            cl = beatIdx % W;
            wv[0] = toSigned(a);
            wv[1] = toSigned(b);
            wv[2] = toSigned(c);
            for (int k = 0; k < 3; k++) frameMem[k][r][cl] = wv[k];
            if ((r % 2 == 1) && (cl % 2 == 1)) begin
                for (int k = 0; k < 3; k++) begin
                    expOut[k] = poolRelu(frameMem[k][r-1][cl-1], frameMem[k][r-1][cl],
                                         frameMem[k][r][cl-1], frameMem[k][r][cl]);
                end
                expStrobe = 1'b1;
            end
            beatIdx = (beatIdx + 1) % (W * H);
        end
        @(posedge clk);
        #1;
        checkOutput("strobe", 32'(valid_out_relu), 32'(expStrobe));
        checkOutput("ch1", 32'(max_value_1), 32'(expOut[0]));
        checkOutput("ch2", 32'(max_value_2), 32'(expOut[1]));
        checkOutput("ch3", 32'(max_value_3), 32'(expOut[2]));
        if (valid_out_relu === 1'b1) begin
            strobeCount++;
            cap1.push_back(int'(max_value_1));
            cap2.push_back(int'(max_value_2));
            cap3.push_back(int'(max_value_3));
        end
    endtask

    task automatic sendBeat(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                            input int gap);
        applyStimulus(1'b1, a, b, c);
        repeat (gap) applyStimulus(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
    endtask

    task automatic rampFrame(input int offset, input int gap, input int beats);
        for (int n = 0; n < beats; n++) begin
            sendBeat(12'(n + offset), 12'(n + offset), 12'(n + offset), gap);
        end
    endtask

    // Pooled ramp value for window k is the bottom-right pixel of that window
    task automatic checkRampValues(input string tag, input int offset, input int firstIdx);
        int exp;
        for (int k = 0; k < 16; k++) begin
            exp = (2 * (k / 4) + 1) * W + 2 * (k % 4) + 1 + offset;
            if (firstIdx + k < cap1.size()) begin
                checkOutput({tag, "_ch1"}, 32'(cap1[firstIdx + k]), 32'(exp));
                checkOutput({tag, "_ch2"}, 32'(cap2[firstIdx + k]), 32'(exp));
                checkOutput({tag, "_ch3"}, 32'(cap3[firstIdx + k]), 32'(exp));
            end
        end
    endtask

    initial begin
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] c;
        int          r;
        int          cl;

        rst_n      = 1'b0;
        valid_in   = 1'b0;
        conv_out_1 = '0;
        conv_out_2 = '0;
        conv_out_3 = '0;
        beatIdx    = 0;
        expStrobe  = 1'b0;
        for (int k = 0; k < 3; k++) expOut[k] = 12'd0;
        clearCapture();

        // Reset held with random traffic on the inputs
        repeat (5) applyStimulus(1'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
        checkOutput("resetStrobes", 32'(strobeCount), 32'd0);
        rst_n = 1'b1;

        // Back-to-back ramp frame
        clearCapture();
        rampFrame(0, 0, W * H);
        checkOutput("rampCount", 32'(strobeCount), 32'd16);
        checkRampValues("ramp", 0, 0);

        // Signed and ReLU corner cases, remaining pixels random
        clearCapture();
        for (int n = 0; n < W * H; n++) begin
            r  = n / W;
            cl = n % W;
            a  = 12'hFFB;
            b  = 12'($urandom);
            c  = 12'($urandom);
            if (r < 2 && cl < 2) begin
                case (r * 2 + cl)
                    0: begin b = 12'h800; c = 12'(-100); end
                    1: begin b = 12'h7FF; c = 12'(-3);   end
                    2: begin b = 12'hF9C; c = 12'(-50);  end
                    default: begin b = 12'h001; c = 12'(-1); end
                endcase
            end
            sendBeat(a, b, c, 0);
        end
        checkOutput("signedCount", 32'(strobeCount), 32'd16);
        if (cap2.size() > 0) begin
            checkOutput("signedCh2First", 32'(cap2[0]), 32'h7FF);
            checkOutput("signedCh3First", 32'(cap3[0]), 32'd0);
        end
        for (int k = 0; k < cap1.size(); k++) checkOutput("reluNegCh1", 32'(cap1[k]), 32'd0);

        // Ramp with two idle cycles after every beat
        clearCapture();
        rampFrame(0, 2, W * H);
        checkOutput("gapCount", 32'(strobeCount), 32'd16);
        checkRampValues("gap", 0, 0);

        // Abort a frame with reset, then a clean frame
        rampFrame(0, 0, 20);
        clearCapture();
        rst_n = 1'b0;
        repeat (2) applyStimulus(1'b1, 12'($urandom), 12'($urandom), 12'($urandom));
        rst_n = 1'b1;
        rampFrame(0, 0, W * H);
        checkOutput("midResetCount", 32'(strobeCount), 32'd16);
        checkRampValues("midReset", 0, 0);

        // Two frames with no gap between them
        clearCapture();
        rampFrame(0, 0, W * H);
        rampFrame(100, 0, W * H);
        checkOutput("twoFrameCount", 32'(strobeCount), 32'd32);
        checkRampValues("frameA", 0, 0);
        checkRampValues("frameB", 100, 16);

        // Random full-range data with random gaps
        clearCapture();
        for (int n = 0; n < W * H; n++) begin
            sendBeat(12'($urandom), 12'($urandom), 12'($urandom), $urandom_range(0, 3));
        end
        checkOutput("randomCount", 32'(strobeCount), 32'd16);

        repeat (3) applyStimulus(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
